// File: rtl/rate_ctrl.sv
// rate_ctrl: selectable-rate tick generator with start/stop/step control.
// Define RATE_CTRL_STEP_EN to compile in the single-step (STEP) state.
module rate_ctrl #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       step,
  input  logic [1:0] rate_sel,
  output logic       tick,
  output logic       running,
  output logic [7:0] tick_count
);

  localparam logic [26:0] DIV_1HZ  = 27'(CLK_HZ);
  localparam logic [26:0] DIV_2HZ  = 27'(CLK_HZ / 2);
  localparam logic [26:0] DIV_4HZ  = 27'(CLK_HZ / 4);
  localparam logic [26:0] DIV_10HZ = 27'(CLK_HZ / 10);

`ifdef RATE_CTRL_STEP_EN
  typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  state_t      state;
  logic [26:0] counter;
  logic [26:0] div;
  logic [26:0] div_sel;

  always_comb begin
    div_sel = DIV_1HZ;
    case (rate_sel)
      2'b00:   div_sel = DIV_1HZ;
      2'b01:   div_sel = DIV_2HZ;
      2'b10:   div_sel = DIV_4HZ;
      default: div_sel = DIV_10HZ;
    endcase
  end

`ifdef RATE_CTRL_STEP_EN
  logic unused_step;
  assign unused_step = 1'b0;
`else
  logic unused_step;
  assign unused_step = step;
`endif

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state      <= IDLE;
      counter    <= '0;
      div        <= DIV_1HZ;
      tick       <= 1'b0;
      running    <= 1'b0;
      tick_count <= '0;
    end else begin
      tick <= 1'b0;
      case (state)
        IDLE: begin
          counter <= '0;
          if (!stop && start) begin
            state   <= RUN;
            running <= 1'b1;
            div     <= div_sel;
          end
`ifdef RATE_CTRL_STEP_EN
          else if (!stop && step) begin
            state <= STEP;
          end
`endif
        end
        RUN: begin
          if (stop) begin
            state   <= IDLE;
            running <= 1'b0;
            counter <= '0;
          end else if (start) begin
            counter <= '0;
            div     <= div_sel;
          end else if (counter >= div - 27'd1) begin
            counter    <= '0;
            tick       <= 1'b1;
            tick_count <= tick_count + 8'd1;
            div        <= div_sel;
          end else begin
            counter <= counter + 27'd1;
          end
        end
`ifdef RATE_CTRL_STEP_EN
        STEP: begin
          // the step tick is issued even if start moves us into RUN
          counter    <= '0;
          tick       <= 1'b1;
          tick_count <= tick_count + 8'd1;
          div        <= div_sel;
          if (!stop && start) begin
            state   <= RUN;
            running <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
`endif
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          counter <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rate_ctrl.sv
// tb_rate_ctrl: deadline-based reference model plus directed scenarios.
// Honours RATE_CTRL_STEP_EN the same way as the design.
module tb_rate_ctrl;

  logic       clk_100MHz = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       step;
  logic [1:0] rate_sel;
  logic       tick;
  logic       running;
  logic [7:0] tick_count;

  int checks = 0;
  int errors = 0;

  rate_ctrl #(.CLK_HZ(100)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .step       (step),
    .rate_sel   (rate_sel),
    .tick       (tick),
    .running    (running),
    .tick_count (tick_count)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  function automatic int divs(input logic [1:0] s);
    case (s)
      2'b00:   return 100;
      2'b01:   return 50;
      2'b10:   return 25;
      default: return 10;
    endcase
  endfunction

  // Model: ticks fall on absolute edge numbers (deadlines).
  int  cyc = 0;
  bit  m_valid = 0;
  bit  m_run, m_step;
  int  deadline;
  bit  e_tick, e_running;
  int  e_count;

  always @(posedge clk_100MHz) begin
    cyc++;
    e_tick = 0;
    if (reset) begin
      m_run = 0; m_step = 0; e_count = 0; m_valid = 1;
    end else if (m_step) begin
      e_tick = 1;
      e_count = (e_count + 1) % 256;
      m_step = 0;
      if (start && !stop) begin
        m_run = 1;
        deadline = cyc + divs(rate_sel);
      end
    end else if (m_run) begin
      if (stop) m_run = 0;
      else if (start) deadline = cyc + divs(rate_sel);
      else if (cyc == deadline) begin
        e_tick = 1;
        e_count = (e_count + 1) % 256;
        deadline = cyc + divs(rate_sel);
      end
    end else begin
      if (start && !stop) begin
        m_run = 1;
        deadline = cyc + divs(rate_sel);
      end
`ifdef RATE_CTRL_STEP_EN
      else if (step && !stop) m_step = 1;
`endif
    end
    e_running = m_run;
  end

  always @(negedge clk_100MHz) begin
    if (m_valid) begin
      checks++;
      if (tick !== e_tick || running !== e_running ||
          tick_count !== 8'(e_count)) begin
        errors++;
        $display("FAIL model cyc=%0d got t=%b r=%b c=%0d exp t=%b r=%b c=%0d",
                 cyc, tick, running, tick_count, e_tick, e_running, e_count);
      end
    end
  end

  int tq[$];
  always @(negedge clk_100MHz) if (tick === 1'b1) tq.push_back(cyc);

  function automatic int tq_at(input int i);
    if (i < tq.size()) return tq[i];
    return -1;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic pulse(input bit a, input bit so, input bit sp,
                       output int k);
    start = a; stop = so; step = sp;
    @(negedge clk_100MHz);
    k = cyc;
    start = 0; stop = 0; step = 0;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk_100MHz);
  endtask

  int k, k2, s, c0;

  initial begin
    reset = 1; start = 0; stop = 0; step = 0; rate_sel = 2'b00;
    repeat (3) @(negedge clk_100MHz);
    chk("rst_tick", int'(tick), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_count", int'(tick_count), 0);
    reset = 0;
    repeat (2) @(negedge clk_100MHz);

    // 1 Hz: first tick DIV edges after start, then every DIV
    tq.delete();
    pulse(1, 0, 0, k);
    wait_to(k + 205);
    chk("run1_n", tq.size(), 2);
    chk("run1_t0", tq_at(0), k + 100);
    chk("run1_t1", tq_at(1), k + 200);
    chk("run1_running", int'(running), 1);

    // rate change mid-period applies from the next tick
    rate_sel = 2'b11;
    tq.delete();
    pulse(1, 0, 0, k2);
    wait_to(k2 + 15);
    rate_sel = 2'b00;
    wait_to(k2 + 125);
    chk("rsel_n", tq.size(), 3);
    chk("rsel_t0", tq_at(0), k2 + 10);
    chk("rsel_t1", tq_at(1), k2 + 20);
    chk("rsel_t2", tq_at(2), k2 + 120);

    // stop on the edge a tick is due
    wait_to(k2 + 219);
    c0 = int'(tick_count);
    pulse(0, 1, 0, k);
    chk("stop_edge", k, k2 + 220);
    chk("stop_tick", int'(tick), 0);
    chk("stop_running", int'(running), 0);
    chk("stop_count", int'(tick_count), c0);
    repeat (5) @(negedge clk_100MHz);

    // single step from IDLE
    tq.delete();
    pulse(0, 0, 1, s);
    repeat (6) @(negedge clk_100MHz);
`ifdef RATE_CTRL_STEP_EN
    chk("step_n", tq.size(), 1);
    chk("step_t0", tq_at(0), s + 1);
`else
    chk("step_n", tq.size(), 0);
`endif

    // all three controls at once in IDLE
    tq.delete();
    pulse(1, 1, 1, s);
    repeat (120) @(negedge clk_100MHz);
    chk("all3_n", tq.size(), 0);
    chk("all3_running", int'(running), 0);

    // 256 ticks at DIV 10 wrap the counter
    reset = 1;
    @(negedge clk_100MHz);
    reset = 0;
    rate_sel = 2'b11;
    pulse(1, 0, 0, k);
    wait_to(k + 2555);
    chk("wrap_255", int'(tick_count), 255);
    wait_to(k + 2562);
    chk("wrap_0", int'(tick_count), 0);
    chk("wrap_running", int'(running), 1);

    // reset on the edge a tick is due
    wait_to(k + 2569);
    reset = 1;
    @(negedge clk_100MHz);
    chk("rstrun_tick", int'(tick), 0);
    chk("rstrun_running", int'(running), 0);
    chk("rstrun_count", int'(tick_count), 0);
    reset = 0;
    repeat (2) @(negedge clk_100MHz);

    // step then start while in STEP; step while running is ignored
    rate_sel = 2'b10;
    pulse(0, 0, 1, s);
    pulse(1, 0, 0, s);
    repeat (12) @(negedge clk_100MHz);
    pulse(0, 0, 1, s);
    rate_sel = 2'b01;
    repeat (80) @(negedge clk_100MHz);
    pulse(1, 0, 0, s);
    repeat (30) @(negedge clk_100MHz);
    pulse(0, 1, 0, s);
    pulse(0, 1, 1, s);
    repeat (10) @(negedge clk_100MHz);
    chk("end_running", int'(running), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
